// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, imem request/ready handshake, instruction register, next-PC select.
// Optional register-indirect jump (jr/jr_target) enabled by defining IFU_JR_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_cond,
`ifdef IFU_JR_EN
    input  logic        jr,
    input  logic [31:0] jr_target,
`endif
    output logic [31:0] instr,
    output logic [5:0]  inst,
    output logic [5:0]  func,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    // state | meaning
    // BOOT  | reset just released, no request yet
    // FETCH | imem_req high, waiting for imem_ready
    // EXEC  | instr valid, waiting for stall low to retire
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] instr_next;
    logic [31:0] branch_offset;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= {RESET_PC[31:2], 2'b00};
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
        end
    end

    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
`ifdef IFU_JR_EN
        if (jr)
            next_pc = {jr_target[31:2], 2'b00};
        else if (jump)
`else
        if (jump)
`endif
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && branch_cond)
            next_pc = pc_plus4 + branch_offset;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_next    = {next_pc[31:2], 2'b00};
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign imem_addr   = pc;
    assign inst        = instr[31:26];
    assign func        = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; a second instance with a high
// RESET_PC exercises the pseudo-direct jump's upper PC bits.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        branch_cond = 1'b0;
`ifdef IFU_JR_EN
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
`endif

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instr, instr2;
    logic [5:0]  inst, inst2, func, func2;
    logic [31:0] pc_plus4, pc_plus4_2;
    logic        instr_valid, instr_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .jump(jump), .branch(branch), .branch_cond(branch_cond),
`ifdef IFU_JR_EN
        .jr(jr), .jr_target(jr_target),
`endif
        .instr(instr), .inst(inst), .func(func),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    instr_fetch_unit #(.RESET_PC(32'h1000_0000)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .jump(jump), .branch(branch), .branch_cond(branch_cond),
`ifdef IFU_JR_EN
        .jr(jr), .jr_target(jr_target),
`endif
        .instr(instr2), .inst(inst2), .func(func2),
        .pc_plus4(pc_plus4_2), .instr_valid(instr_valid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic chk_exec(input string tag, input logic [31:0] ins, input logic [31:0] pp4);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, ins);
        chk({tag, "_inst"}, {26'd0, inst}, {26'd0, ins[31:26]});
        chk({tag, "_func"}, {26'd0, func}, {26'd0, ins[5:0]});
        chk({tag, "_pc4"}, pc_plus4, pp4);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0100);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_inst"}, {26'd0, inst}, 32'd0);
        chk({tag, "_func"}, {26'd0, func}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_pc4"}, pc_plus4, 32'h0000_0104);
    endtask

    initial begin
        // reset values while held
        tick();
        tick();
        chk_reset("rst");
        chk("rst2_addr", imem_addr2, 32'h1000_0000);

        // zero-wait fetch: 0x100, 0x104, 0x108
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_fetch("f100", 32'h0000_0100);
        imem_ready = 1'b1;
        imem_rdata = 32'h0043_1020;
        tick();
        chk_exec("e100", 32'h0043_1020, 32'h0000_0104);
        tick();
        chk_fetch("f104", 32'h0000_0104);
        imem_rdata = 32'h0000_0000;
        tick();
        chk_exec("e104", 32'h0000_0000, 32'h0000_0108);
        tick();
        chk_fetch("f108", 32'h0000_0108);

        // three wait cycles, capture on the fourth edge; the captured instr is J 0x200
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("wait", 32'h0000_0108);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0080;
        tick();
        chk_exec("ej", 32'h0800_0080, 32'h0000_010C);
        jump = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        jump = 1'b0;
        chk_fetch("f200", 32'h0000_0200);

        // taken branch, imm -2 words
        imem_rdata = 32'h1000_FFFE;
        tick();
        chk_exec("ebr", 32'h1000_FFFE, 32'h0000_0204);
        branch = 1'b1;
        branch_cond = 1'b1;
        tick();
        branch = 1'b0;
        branch_cond = 1'b0;
        chk_fetch("f1fc", 32'h0000_01FC);

        imem_rdata = 32'h0800_0080;
        tick();
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk_fetch("f200b", 32'h0000_0200);

        // not-taken branch
        imem_rdata = 32'h1000_FFFE;
        tick();
        branch = 1'b1;
        branch_cond = 1'b0;
        tick();
        branch = 1'b0;
        chk_fetch("f204", 32'h0000_0204);

        // stall held 5 cycles, late imem_ready/rdata ignored
        imem_rdata = 32'h8C43_0008;
        tick();
        chk_exec("elw", 32'h8C43_0008, 32'h0000_0208);
        stall = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_exec("stall", 32'h8C43_0008, 32'h0000_0208);
        end
        stall = 1'b0;
        tick();
        chk_fetch("f208", 32'h0000_0208);

        // reset pulsed during FETCH wait
        imem_ready = 1'b0;
        tick();
        chk_fetch("w208", 32'h0000_0208);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0040;
        tick();
        chk_reset("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_fetch("boot_ign", 32'h0000_0100);
        chk("boot_ign_instr", instr, 32'd0);

        // jump wins over branch; dut2 exercises upper PC bits
        chk("f2_addr", imem_addr2, 32'h1000_0000);
        tick();
        chk_exec("ejb", 32'h0800_0040, 32'h0000_0104);
        chk("ejb2_instr", instr2, 32'h0800_0040);
        jump = 1'b1;
        branch = 1'b1;
        branch_cond = 1'b1;
        tick();
        jump = 1'b0;
        branch = 1'b0;
        branch_cond = 1'b0;
        chk_fetch("fjb", 32'h0000_0100);
        chk("fjb2_addr", imem_addr2, 32'h1000_0100);
        chk("fjb2_req", {31'd0, imem_req2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
